// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types for the data-memory write buffer: the buffered
//                store entry, byte-lane mask constants and the flush FSM
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // Word address width carried in an entry; wide enough for any RAM depth.
  // The top level zero-extends its AW-bit word index into this field.
  localparam int unsigned WADDR_W = 30;

  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_B0   = 4'b0001;
  localparam logic [3:0] MASK_B1   = 4'b0010;
  localparam logic [3:0] MASK_B2   = 4'b0100;
  localparam logic [3:0] MASK_B3   = 4'b1000;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [31:0]        data;
    logic [3:0]         mask;
  } entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_wbuf_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_wbuf_if
//  Description : Core <-> data-memory bus.
//                master (core)   : drives MemWrite, ByteEn, Flush, ALUResult,
//                                  WriteData; receives ReadData, Stall, Empty
//                slave  (memory) : the reverse
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_wbuf_if;
  logic        MemWrite;
  logic        ByteEn;
  logic        Flush;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Empty;

  modport master (
    output MemWrite, ByteEn, Flush, ALUResult, WriteData,
    input  ReadData, Stall, Empty
  );

  modport slave (
    input  MemWrite, ByteEn, Flush, ALUResult, WriteData,
    output ReadData, Stall, Empty
  );
endinterface
`default_nettype wire

// File: rtl/dmem_wbuf_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wbuf_fifo
//  Description : Circular store buffer. Holds DEPTH entries, tracks head,
//                tail and count, and exposes every slot plus a per-slot valid
//                vector so the top level can forward load data.
//  Ports       : clk, reset (sync, active-low)
//                i_push  - append i_entry at the tail
//                i_pop   - retire the head entry
//                i_merge - fold i_entry into the newest entry (coalescing)
//                o_entries / o_valid / o_head / o_count - buffer state
//  Revision    : 1.0  initial release
// ============================================================================
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   i_push,
  input  wire logic   i_pop,
  input  wire logic   i_merge,
  input  wire entry_t i_entry,
  output entry_t      o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid,
  output logic [PW-1:0]    o_head,
  output logic [CW-1:0]    o_count
);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_newest;
  entry_t        w_merged;

  assign w_newest = r_tail - PW'(1);

  // Newest entry with the incoming lanes laid over it.
  always_comb begin
    w_merged      = r_mem[w_newest];
    w_merged.mask = w_merged.mask | i_entry.mask;
    for (int l = 0; l < 4; l++) begin
      if (i_entry.mask[l]) w_merged.data[8*l +: 8] = i_entry.data[8*l +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_entry;
        r_tail        <= r_tail + PW'(1);
      end
      if (i_merge) r_mem[w_newest] <= w_merged;
      if (i_pop)   r_head <= r_head + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    logic [PW-1:0] v_off;
    o_valid = '0;
    for (int j = 0; j < DEPTH; j++) begin
      v_off      = PW'(j) - r_head;
      o_valid[j] = ({1'b0, v_off} < r_count);
    end
  end

  assign o_entries = r_mem;
  assign o_head    = r_head;
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_wbuf
//  Description : Data-memory stage with a posted write buffer. Stores are
//                queued and drained into the RAM one per cycle; loads merge
//                queued bytes over the RAM word so the core sees ordinary
//                single-cycle memory. Stall only on a full buffer or flush.
//  Ports       : clk, reset (sync, active-low), bus (dmem_wbuf_if.slave)
//  Config      : WBUF_COALESCE_EN - merge a store into the newest entry when
//                its word address matches instead of pushing a new entry.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 64
) (
  input wire logic    clk,
  input wire logic    reset,
  dmem_wbuf_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    w_word;
  entry_t           w_entry;
  entry_t           w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [PW-1:0]    w_head;
  logic [CW-1:0]    w_count;
  logic             w_empty, w_full, w_pop, w_hit, w_stall;
  logic             w_accept, w_push, w_merge;
  logic [31:0]      w_rdata;
  logic [31:0]      r_ram [MEM_WORDS];
  state_t           r_state;
  logic             w_unused;

  assign w_word   = bus.ALUResult[AW+1:2];
  assign w_unused = ^bus.ALUResult[31:AW+2];

  always_comb begin
    w_entry.addr = WADDR_W'(w_word);
    w_entry.data = bus.WriteData;
    w_entry.mask = MASK_WORD;
    if (bus.ByteEn) begin
      w_entry.data = {4{bus.WriteData[7:0]}};
      case (bus.ALUResult[1:0])
        2'd0: w_entry.mask = MASK_B0;
        2'd1: w_entry.mask = MASK_B1;
        2'd2: w_entry.mask = MASK_B2;
        2'd3: w_entry.mask = MASK_B3;
      endcase
    end
  end

  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == CW'(DEPTH));
  // Contents are discarded, not committed, while reset is held.
  assign w_pop   = !w_empty && reset;

`ifdef WBUF_COALESCE_EN
  logic [PW-1:0] w_newest;
  assign w_newest = w_head + PW'(w_count - CW'(1));
  // The newest entry cannot absorb a store if it is the head leaving now.
  assign w_hit = !w_empty && (w_entries[w_newest].addr == w_entry.addr)
                 && !((w_count == CW'(1)) && w_pop);
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      RUN:   w_stall = bus.MemWrite && w_full && !w_hit;
      FLUSH: w_stall = !w_empty;
    endcase
  end

  assign w_accept = bus.MemWrite && !w_stall;
  assign w_push   = w_accept && !w_hit;
  assign w_merge  = w_accept && w_hit;

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_merge   (w_merge),
    .i_entry   (w_entry),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  // Flush FSM; an empty buffer never enters FLUSH, so it costs no stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:   if (bus.Flush && !w_empty) r_state <= FLUSH;
        FLUSH: if (w_empty)               r_state <= RUN;
      endcase
    end
  end

  // Head entry commits under its byte mask.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      for (int l = 0; l < 4; l++) begin
        if (w_entries[w_head].mask[l])
          r_ram[w_entries[w_head].addr[AW-1:0]][8*l +: 8] <= w_entries[w_head].data[8*l +: 8];
      end
    end
  end

  // Forwarding walks oldest to newest so the youngest store wins each lane.
  always_comb begin
    logic [PW-1:0] v_idx;
    w_rdata = r_ram[w_word];
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = w_head + PW'(k);
      if (w_valid[v_idx] && (w_entries[v_idx].addr == w_entry.addr)) begin
        for (int l = 0; l < 4; l++) begin
          if (w_entries[v_idx].mask[l]) w_rdata[8*l +: 8] = w_entries[v_idx].data[8*l +: 8];
        end
      end
    end
  end

  assign bus.ReadData = w_rdata;
  assign bus.Stall    = w_stall;
  assign bus.Empty    = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_dmem_wbuf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_wbuf
//  Description : Self-checking bench for dmem_wbuf. A queue-of-stores plus
//                flat memory array predicts ReadData, Stall and Empty every
//                cycle; directed scenarios are followed by random traffic.
//                The RAM drain can be held off by forcing dut.w_pop low.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_wbuf;

  typedef struct {
    bit [5:0]  a;
    bit [31:0] d;
    bit [3:0]  m;
  } ment_t;

  logic clk = 1'b0;
  logic reset;
  dmem_wbuf_if bus();

  dmem_wbuf #(.DEPTH(4), .MEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  bit        chk_rd   = 1'b1;
  bit [31:0] mdl_mem [64];
  ment_t     q [$];
  bit        mdl_flush = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] mdl_read(input bit [5:0] w);
    bit [31:0] r;
    r = mdl_mem[w];
    foreach (q[i]) begin
      if (q[i].a == w)
        for (int l = 0; l < 4; l++)
          if (q[i].m[l]) r[8*l +: 8] = q[i].d[8*l +: 8];
    end
    return r;
  endfunction

  // One core cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit mw, input bit be, input bit fl,
                      input bit [31:0] a, input bit [31:0] d, input bit blk,
                      input string tag, output bit st);
    bit [5:0] w;
    ment_t    e;
    bit       hit, exp_st;
    int       n;
    @(negedge clk);
    bus.MemWrite  = mw;
    bus.ByteEn    = be;
    bus.Flush     = fl;
    bus.ALUResult = a;
    bus.WriteData = d;
    if (blk) force dut.w_pop = 1'b0;
    else     release dut.w_pop;
    #1;
    w   = a[7:2];
    n   = q.size();
    e.a = w;
    if (be) begin
      e.m = 4'b0001 << a[1:0];
      e.d = {4{d[7:0]}};
    end else begin
      e.m = 4'hF;
      e.d = d;
    end
    hit = 1'b0;
`ifdef WBUF_COALESCE_EN
    if (n >= 2 || (n == 1 && blk)) hit = (q[n-1].a == w);
`endif
    exp_st = mdl_flush ? (n != 0) : (mw && (n == 4) && !hit);
    if (chk_rd) chk({tag, ".rd"}, bus.ReadData, mdl_read(w));
    chk({tag, ".stall"}, 32'(bus.Stall), 32'(exp_st));
    chk({tag, ".empty"}, 32'(bus.Empty), 32'(n == 0));
    st = bus.Stall;
    if (mw && !exp_st && hit) begin
      q[n-1].m = q[n-1].m | e.m;
      for (int l = 0; l < 4; l++) if (e.m[l]) q[n-1].d[8*l +: 8] = e.d[8*l +: 8];
    end
    if (n > 0 && !blk) begin
      for (int l = 0; l < 4; l++) if (q[0].m[l]) mdl_mem[q[0].a][8*l +: 8] = q[0].d[8*l +: 8];
      void'(q.pop_front());
    end
    if (mw && !exp_st && !hit) q.push_back(e);
    mdl_flush = mdl_flush ? (n != 0) : (fl && n != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    release dut.w_pop;
    reset        = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Flush    = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    q.delete();
    mdl_flush = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        st;
    bit [31:0] v, pre38;
    int        ns;
    reset         = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ByteEn    = 1'b0;
    bus.Flush     = 1'b0;
    bus.ALUResult = '0;
    bus.WriteData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Preload every RAM word through ordinary stores.
    chk_rd = 1'b0;
    for (int w = 0; w < 64; w++) begin
      v = (w == 4) ? 32'hCAFE0004 : (w == 16) ? 32'h11223344 : $urandom;
      step(1, 0, 0, ($urandom & 32'hFFFF_FF00) | 32'(w << 2), v, 0, "pre", st);
    end
    chk_rd = 1'b1;
    step(0, 0, 0, 32'h0, 0, 0, "pre.idle", st);
    do_reset();

    // Reset state and plain load.
    step(0, 0, 0, 32'h10, 0, 0, "rst", st);
    chk("rst.rd_const", bus.ReadData, 32'hCAFE0004);
    chk("rst.empty_const", 32'(bus.Empty), 32'd1);

    // Word store then immediate load.
    step(1, 0, 0, 32'h20, 32'hDEADBEEF, 0, "sw", st);
    step(0, 0, 0, 32'h20, 0, 0, "sw.ld1", st);
    chk("sw.fwd_const", bus.ReadData, 32'hDEADBEEF);
    step(0, 0, 0, 32'h20, 0, 0, "sw.ld2", st);
    chk("sw.ram_const", bus.ReadData, 32'hDEADBEEF);
    chk("sw.empty_const", 32'(bus.Empty), 32'd1);

    // Back-to-back byte stores over 0x11223344.
    step(1, 1, 0, 32'h41, 32'h000000AA, 0, "sb1", st);
    step(1, 1, 0, 32'h43, 32'h00000055, 0, "sb2", st);
    step(0, 0, 0, 32'h40, 0, 0, "sb.ld1", st);
    chk("sb.fwd_const", bus.ReadData, 32'h5522AA44);
    step(0, 0, 0, 32'h40, 0, 0, "sb.ld2", st);
    chk("sb.ram_const", bus.ReadData, 32'h5522AA44);

    // Fill with the drain held off; the fifth store must wait.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 32'hC0 + 32'(4*i), 32'hA000_0000 + 32'(i), 1, "full.push", st);
      chk("full.push_nostall", 32'(st), 32'd0);
    end
    step(1, 0, 0, 32'hD0, 32'hA000_0004, 1, "full.fifth_blk", st);
    chk("full.fifth_stall", 32'(st), 32'd1);
    step(1, 0, 0, 32'hD0, 32'hA000_0004, 0, "full.fifth_drain", st);
    chk("full.fifth_still", 32'(st), 32'd1);
    step(1, 0, 0, 32'hD0, 32'hA000_0004, 0, "full.fifth_go", st);
    chk("full.fifth_accept", 32'(st), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'hC0 + 32'(4*(i % 5)), 0, 0, "full.ld", st);
    step(0, 0, 0, 32'hD0, 0, 0, "full.ld5", st);
    chk("full.ram5_const", bus.ReadData, 32'hA000_0004);

    // Flush with three queued entries.
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 32'hE0 + 32'(4*i), $urandom, 1, "fl.push", st);
    step(0, 0, 1, 32'hE0, 0, 0, "fl.req", st);
    ns = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 32'hE4, 0, 0, "fl.wait", st);
      ns += int'(st);
    end
    chk("fl.stall_cycles", 32'(ns), 32'd2);

    // Flush while empty: no stall even with stores following.
    step(1, 0, 1, 32'h30, 32'h0BADF00D, 0, "fl0.req", st);
    chk("fl0.nostall_req", 32'(st), 32'd0);
    step(1, 0, 0, 32'h34, 32'h12345678, 0, "fl0.next", st);
    chk("fl0.nostall_next", 32'(st), 32'd0);
    step(0, 0, 0, 32'h30, 0, 0, "fl0.idle", st);

    // Reset with two entries queued.
    pre38 = mdl_mem[6'h38];
    step(1, 0, 0, 32'hDC, 32'h77777777, 0, "rq.drained", st);
    step(0, 0, 0, 32'hDC, 0, 0, "rq.idle", st);
    step(1, 0, 0, 32'hE0, 32'h88888888, 1, "rq.q1", st);
    step(1, 0, 0, 32'hE4, 32'h99999999, 1, "rq.q2", st);
    do_reset();
    step(0, 0, 0, 32'hE0, 0, 0, "rq.ld", st);
    chk("rq.ram_const", bus.ReadData, pre38);
    chk("rq.empty_const", 32'(bus.Empty), 32'd1);
    step(0, 0, 0, 32'hDC, 0, 0, "rq.kept", st);
    chk("rq.kept_const", bus.ReadData, 32'h77777777);

    // Random traffic over a small address window to exercise forwarding.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0),
           $urandom & 32'hFFFF_FF1F, $urandom,
           ($urandom_range(0, 3) == 0), "rnd", st);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'(i << 2), 0, 0, "rnd.tail", st);

    @(negedge clk);
    release dut.w_pop;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
